// File: rtl/lut_neuron_table_loader.sv
// Runtime-writable LUT neuron: streamed table loader plus a 1-cycle registered lookup port.
// Optional macro CHECKSUM_EN adds a trailing XOR checksum word with CHECK/ERR states.
module lut_neuron_table_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2,
    parameter int CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_ready,
    output logic                loaded,
    output logic                cfg_err,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  M0,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] M1
);

    localparam int ENTRIES = 2 ** IN_BITS;
    localparam int EPW     = CFG_W / OUT_BITS;
    localparam int WORDS   = (ENTRIES * OUT_BITS) / CFG_W;
    localparam int CW      = (WORDS > 1) ? $clog2(WORDS) : 1;

    generate
        if (((CFG_W % OUT_BITS) != 0) || (((ENTRIES * OUT_BITS) % CFG_W) != 0)) begin : g_bad_cfg
            $error("lut_neuron_table_loader: CFG_W must be a multiple of OUT_BITS and divide the table size");
        end
    endgenerate

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, DONE = 3'd2, CHECK = 3'd3, ERR = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, DONE = 3'd2} state_t;
`endif

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CW-1:0]         word_cnt_r;
    logic [CW-1:0]         word_cnt_nxt_s;
    logic                  wr_en_s;
    logic [IN_BITS-1:0]    wr_base_s;
    logic [OUT_BITS-1:0]   table_r [ENTRIES];

`ifdef CHECKSUM_EN
    logic [CFG_W-1:0]      csum_r;
    logic [CFG_W-1:0]      csum_nxt_s;

    function automatic logic [CFG_W-1:0] csum_fold(input logic [CFG_W-1:0] acc, input logic [CFG_W-1:0] word);
        return acc ^ word;
    endfunction
`endif

    assign wr_base_s = IN_BITS'(int'(word_cnt_r) * EPW);

    // Next-state, word counter and table write enable; cfg_start overrides any handshake.
    always_comb begin
        state_nxt_s    = state_r;
        word_cnt_nxt_s = word_cnt_r;
        wr_en_s        = 1'b0;
`ifdef CHECKSUM_EN
        csum_nxt_s     = csum_r;
`endif
        if (cfg_start) begin
            state_nxt_s    = LOAD;
            word_cnt_nxt_s = '0;
`ifdef CHECKSUM_EN
            csum_nxt_s     = '0;
`endif
        end else begin
            case (state_r)
                LOAD: begin
                    if (cfg_valid) begin
                        wr_en_s = 1'b1;
`ifdef CHECKSUM_EN
                        csum_nxt_s = csum_fold(csum_r, cfg_data);
`endif
                        if (word_cnt_r == CW'(WORDS - 1)) begin
`ifdef CHECKSUM_EN
                            state_nxt_s = CHECK;
`else
                            state_nxt_s = DONE;
`endif
                        end else begin
                            word_cnt_nxt_s = word_cnt_r + CW'(1);
                        end
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end
`ifdef CHECKSUM_EN
                CHECK: begin
                    if (cfg_valid) begin
                        state_nxt_s = (cfg_data == csum_r) ? DONE : ERR;
                    end else begin
                        state_nxt_s = CHECK;
                    end
                end
`endif
                default: begin
                    state_nxt_s = state_r;
                end
            endcase
        end
    end

    // Control state plus registered status and lookup outputs (synchronous reset).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            word_cnt_r <= '0;
            cfg_ready  <= 1'b0;
            loaded     <= 1'b0;
            out_valid  <= 1'b0;
            M1         <= '0;
`ifdef CHECKSUM_EN
            csum_r     <= '0;
            cfg_err    <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            word_cnt_r <= word_cnt_nxt_s;
            loaded     <= (state_nxt_s == DONE);
            out_valid  <= in_valid & loaded;
`ifdef CHECKSUM_EN
            csum_r     <= csum_nxt_s;
            cfg_err    <= (state_nxt_s == ERR);
            cfg_ready  <= (state_nxt_s == LOAD) || (state_nxt_s == CHECK);
`else
            cfg_ready  <= (state_nxt_s == LOAD);
`endif
            // loaded is the registered flag, so a lookup in the cfg_start cycle still sees the old table
            if (in_valid && loaded) begin
                M1 <= table_r[M0];
            end else begin
                M1 <= M1;
            end
        end
    end

`ifndef CHECKSUM_EN
    assign cfg_err = 1'b0;
`endif

    // Table storage: one wide write per accepted word, no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            for (int j = 0; j < EPW; j++) begin
                table_r[wr_base_s + IN_BITS'(j)] <= cfg_data[j*OUT_BITS +: OUT_BITS];
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// Randomized and directed bench for lut_neuron_table_loader against a behavioural table model.
module tb_lut_neuron_table_loader;

    localparam int IN_BITS  = 6;
    localparam int OUT_BITS = 2;
    localparam int CFG_W    = 8;
    localparam int ENTRIES  = 2 ** IN_BITS;
    localparam int EPW      = CFG_W / OUT_BITS;
    localparam int WORDS    = (ENTRIES * OUT_BITS) / CFG_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_start = 1'b0;
    logic                cfg_valid = 1'b0;
    logic [CFG_W-1:0]    cfg_data = '0;
    logic                cfg_ready;
    logic                loaded;
    logic                cfg_err;
    logic                in_valid = 1'b0;
    logic [IN_BITS-1:0]  M0 = '0;
    logic                out_valid;
    logic [OUT_BITS-1:0] M1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b1;

    lut_neuron_table_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFG_W(CFG_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready), .loaded(loaded), .cfg_err(cfg_err),
        .in_valid(in_valid), .M0(M0), .out_valid(out_valid), .M1(M1)
    );

    always #5 clk = ~clk;

    // Reference model: the table contents, how many words of the current load were taken,
    // and the running XOR of those words.
    logic [OUT_BITS-1:0] mtab [ENTRIES];
    int                  m_taken = 0;
    logic [CFG_W-1:0]    m_x = '0;
    bit                  m_ready = 1'b0;
    bit                  m_loaded = 1'b0;
    bit                  m_err = 1'b0;
    bit                  e_ov = 1'b0;
    logic [OUT_BITS-1:0] e_m1 = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            e_ov <= 1'b0; e_m1 <= '0; m_ready <= 1'b0; m_loaded <= 1'b0;
            m_err <= 1'b0; m_taken <= 0; m_x <= '0;
        end else begin
            e_ov <= in_valid && m_loaded;
            if (in_valid && m_loaded) e_m1 <= mtab[M0];
            if (cfg_start) begin
                m_taken <= 0; m_ready <= 1'b1; m_loaded <= 1'b0; m_err <= 1'b0; m_x <= '0;
            end else if (m_ready && cfg_valid) begin
                if (m_taken < WORDS) begin
                    for (int j = 0; j < EPW; j++)
                        mtab[m_taken*EPW + j] <= cfg_data[j*OUT_BITS +: OUT_BITS];
                    m_x <= m_x ^ cfg_data;
                    m_taken <= m_taken + 1;
`ifndef CHECKSUM_EN
                    if (m_taken + 1 == WORDS) begin
                        m_ready <= 1'b0; m_loaded <= 1'b1;
                    end
`endif
                end else begin
                    m_ready <= 1'b0;
                    if (cfg_data == m_x) m_loaded <= 1'b1;
                    else m_err <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("M1", 32'(M1), 32'(e_m1));
            chk("loaded", 32'(loaded), 32'(m_loaded));
            chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    endtask

    task automatic send_words(input logic [CFG_W-1:0] val, input int n);
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1; cfg_data = val; tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic lookup(input string name, input logic [IN_BITS-1:0] a, input logic [OUT_BITS-1:0] exp);
        in_valid = 1'b1; M0 = a; tick(); in_valid = 1'b0;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk(name, 32'(M1), 32'(exp));
    endtask

    initial begin
        int cnt;
        // reset with a lookup pending
        rst_n = 1'b0; in_valid = 1'b1; M0 = 6'd7;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_M1", 32'(M1), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1; tick();
        chk("pre_load_lookup", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // load E4 with a 10-cycle stall after word 7; lookups during the load
        start_pulse();
        in_valid = 1'b1; M0 = 6'd5;
        send_words(8'hE4, 7);
        for (int k = 0; k < 10; k++) tick();
        chk("stall_word_cnt", 32'(dut.word_cnt_r), 32'd7);
        chk("stall_loaded", 32'(loaded), 32'd0);
        chk("during_load_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        send_words(8'hE4, WORDS - 8);
        in_valid = 1'b1; M0 = 6'd63;
`ifdef CHECKSUM_EN
        send_words(8'hE4, 1);
        send_words(8'h00, 1);
`else
        send_words(8'hE4, 1);
`endif
        in_valid = 1'b0;
        chk("final_write_lookup", 32'(out_valid), 32'd0);
        chk("loaded_after_last", 32'(loaded), 32'd1);
        lookup("e4_m5", 6'd5, 2'b01);
        lookup("e4_m63", 6'd63, 2'b11);

        // stream all addresses back to back
        cnt = 0;
        for (int a = 0; a < ENTRIES; a++) begin
            in_valid = 1'b1; M0 = IN_BITS'(a); tick();
            if (out_valid && M1 == 2'(a % 4)) cnt++;
        end
        in_valid = 1'b0;
        chk("stream_count", 32'(cnt), 32'd64);

        // lookup in the cfg_start cycle sees the old table; then abort after word 9
        in_valid = 1'b1; M0 = 6'd6; cfg_start = 1'b1; tick(); cfg_start = 1'b0; in_valid = 1'b0;
        chk("start_cycle_valid", 32'(out_valid), 32'd1);
        chk("start_cycle_M1", 32'(M1), 32'd2);
        send_words(8'hE4, 9);
        start_pulse();
        chk("restart_loaded", 32'(loaded), 32'd0);
        send_words(8'h1B, WORDS);
`ifdef CHECKSUM_EN
        send_words(8'h00, 1);
`endif
        chk("reload_loaded", 32'(loaded), 32'd1);
        lookup("1b_m0", 6'd0, 2'b11);
        lookup("1b_m3", 6'd3, 2'b00);

`ifdef CHECKSUM_EN
        start_pulse();
        send_words(8'hE4, WORDS);
        send_words(8'h01, 1);
        chk("csum_err", 32'(cfg_err), 32'd1);
        chk("csum_err_loaded", 32'(loaded), 32'd0);
        in_valid = 1'b1; M0 = 6'd1; tick(); in_valid = 1'b0;
        chk("csum_err_lookup", 32'(out_valid), 32'd0);
        start_pulse();
        chk("csum_err_cleared", 32'(cfg_err), 32'd0);
`endif

        // randomized traffic: loads, stalls, aborts, stray valids, lookups, resets
        for (int c = 0; c < 4000; c++) begin
            rst_n     = ($urandom_range(0, 799) != 0);
            in_valid  = $urandom_range(0, 1) != 0;
            M0        = IN_BITS'($urandom);
            cfg_start = ($urandom_range(0, 149) == 0) ||
                        (!m_ready && $urandom_range(0, 14) == 0);
            cfg_valid = $urandom_range(0, 3) != 0;
            cfg_data  = CFG_W'($urandom);
            if (m_taken == WORDS && $urandom_range(0, 1) != 0) cfg_data = m_x;
            tick();
        end
        cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
